seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/seq_muldiv.sv | 82 ++++++++
 rtl/seq_alu.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and sequencer states, also used by the
// control unit's ALU-control decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULTU = 4'b1000,
        OP_DIVU  = 4'b1001,
        OP_MFHI  = 4'b1010,
        OP_MFLO  = 4'b1011
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// hi/lo present the result of the step in progress so the final step lands directly in the caller.
module seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             busy;
    logic             div_q;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Multiply: {hi,lo} is the product/multiplier pair, a_q the multiplicand.
    // Divide: hi is the partial remainder, lo the dividend/quotient, a_q the divisor.
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, a_q};
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, a_q};
        hi_n    = hi_q;
        lo_n    = lo_q;
        if (div_q) begin
            if (!diff[WIDTH]) begin
                hi_n = diff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            {hi_n, lo_n} = {sum, lo_q[WIDTH-1:1]};
        end else begin
            {hi_n, lo_n} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            a_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            div_q <= is_div;
            cnt   <= '0;
            a_q   <= is_div ? b : a;
            hi_q  <= '0;
            lo_q  <= is_div ? a : b;
        end else if (busy) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            cnt  <= cnt + 1'b1;
            if (cnt == SHW'(WIDTH - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (cnt == SHW'(WIDTH - 1));
    assign hi   = hi_n;
    assign lo   = lo_n;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete at the accept edge; MULTU/DIVU run
// through seq_muldiv and write the HI/LO pair. Handshake: a request is taken on a rising edge with in_valid && in_ready.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero
);

    state_e           state;
    state_e           state_next;
    logic             accept;
    logic             div_zero;
    logic             md_start;
    logic             md_is_div;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] alu_res;

    assign in_ready  = (state == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign div_zero  = (dataB == '0);
    assign md_is_div = (op == OP_DIVU);
    assign md_start  = accept && ((op == OP_MULTU) || ((op == OP_DIVU) && !div_zero));

    seq_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (md_is_div),
        .a      (dataA),
        .b      (dataB),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_comb begin
        alu_res = '0;
        case (op_e'(op))
            OP_AND:  alu_res = dataA & dataB;
            OP_OR:   alu_res = dataA | dataB;
            OP_ADD:  alu_res = dataA + dataB;
            OP_SUB:  alu_res = dataA - dataB;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            OP_SLL:  alu_res = dataB << shamt;
            OP_SRL:  alu_res = dataB >> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept && (op == OP_MULTU)) begin
                    state_next = S_MUL;
                end else if (accept && (op == OP_DIVU)) begin
                    state_next = div_zero ? S_DONE : S_DIV;
                end
            end
            S_MUL:   if (md_done) state_next = S_DONE;
            S_DIV:   if (md_done) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Results are written on the edge that enters DONE, so out_valid rises with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q      <= '0;
            lo_q      <= '0;
            dataOut   <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_muldiv(op)) begin
                dataOut   <= alu_res;
                zero      <= (alu_res == '0);
                out_valid <= 1'b1;
            end else if (accept && (op == OP_DIVU) && div_zero) begin
                hi_q      <= dataA;
                lo_q      <= '1;
                dataOut   <= '1;
                zero      <= 1'b0;
                out_valid <= 1'b1;
            end else if (((state == S_MUL) || (state == S_DIV)) && md_done) begin
                hi_q      <= md_hi;
                lo_q      <= md_lo;
                dataOut   <= md_lo;
                zero      <= (md_lo == '0);
                out_valid <= 1'b1;
            end
        end
    end

endmodule
